// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative signed multiply/divide engine that owns the HI/LO result registers.
// The control unit pulses `start` with the rs/rt operands. The engine works on
// operand magnitudes, one bit per cycle: shift-add for MULT, restoring division
// for DIV. A single FIX cycle then applies sign correction and writes HI/LO.
// Completion, or an immediate divide-by-zero, is reported with a one-cycle
// `done`.
//
// Ports
//   clk       : clock; all state changes on the rising edge
//   reset     : synchronous, active-low
//   start     : request pulse, accepted only while idle
//   op        : 0 = MULT, 1 = DIV (sampled with start)
//   src_a     : rs, multiplicand / dividend (two's complement)
//   src_b     : rt, multiplier / divisor (two's complement)
//   busy      : high in every state except IDLE
//   done      : one-cycle completion pulse
//   div_zero  : coincident with done when a DIV had a zero divisor
//   hi_out    : HI register (MULT upper product / DIV remainder)
//   lo_out    : LO register (MULT lower product / DIV quotient)
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               sign_a;
    logic               sign_b;
    logic               dz_flag;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic signed [WIDTH-1:0] a_signed;
    logic signed [WIDTH-1:0] b_signed;

    logic               accept;
    logic               last_iter;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // |v| as an unsigned value; the most negative input maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_if_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? -v : v;
    endfunction

    assign a_signed  = $signed(src_a);
    assign b_signed  = $signed(src_b);
    assign accept    = (state == IDLE) && start;
    assign last_iter = (cnt == LAST_ITER);

    // Shift-add step: low half holds the remaining multiplier bits, high half
    // the partial product. Add the multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    assign mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mult_next = {mult_sum, acc[WIDTH-1:1]};

    // Restoring division step: high half is the partial remainder, low half
    // shifts out dividend bits and shifts in quotient bits. The remainder is
    // always below the divisor, so the shifted value fits in WIDTH+1 bits and
    // bit WIDTH of the trial difference is its sign.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, mag_b};
    assign div_rem   = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign div_next  = {div_rem, acc[WIDTH-2:0], ~div_trial[WIDTH]};

    // Sign correction: quotient negative when signs differ, remainder follows
    // the dividend (truncation toward zero).
    assign product = neg_if_wide(acc, sign_a ^ sign_b);

    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (op_div) begin
            fix_hi = neg_if(acc[2*WIDTH-1:WIDTH], sign_a);
            fix_lo = neg_if(acc[WIDTH-1:0], sign_a ^ sign_b);
        end else begin
            fix_hi = product[2*WIDTH-1:WIDTH];
            fix_lo = product[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        div_zero   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_next = MULT;
                    end else if (src_b == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MULT, DIV: begin
                if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                div_zero   = dz_flag;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            op_div  <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            dz_flag <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            op_div  <= op;
            sign_a  <= (a_signed < 0);
            sign_b  <= (b_signed < 0);
            dz_flag <= op && (src_b == '0);
        end else if ((state == MULT) || (state == DIV)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Operand magnitudes and the shared accumulator carry no reset; they are
    // always loaded on acceptance before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            mag_a <= magnitude(a_signed);
            mag_b <= magnitude(b_signed);
            acc   <= op ? {{WIDTH{1'b0}}, magnitude(a_signed)}
                        : {{WIDTH{1'b0}}, magnitude(b_signed)};
        end else if (state == MULT) begin
            acc <= mult_next;
        end else if (state == DIV) begin
            acc <= div_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_out <= '0;
            lo_out <= '0;
        end else if (state == FIX) begin
            hi_out <= fix_hi;
            lo_out <= fix_lo;
        end
    end

endmodule
